// File: rtl/memory_stage.sv
// Memory stage of the WISC-SP13 pipeline: data-memory access over a request/done
// handshake, branch/jump resolution and registered writeback toward decode.
module memory_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [15:0] ALUResult_In,
   input  logic [15:0] RD2_In,
   input  logic [2:0]  WR_In,
   input  logic        RegWrite_In,
   input  logic [1:0]  RegWriteDataSel_In,
   input  logic        MemReadEn_In,
   input  logic        MemWriteEn_In,
   input  logic        Branch_In,
   input  logic        Jump_In,
   input  logic        Halt_In,
   input  logic [2:0]  SelFlag_In,
   input  logic        Z_In,
   input  logic        N_In,
   input  logic        Ofl_In,
   input  logic        Cout_In,
   input  logic [15:0] BJAddr_In,
   input  logic [15:0] PCInc_In,
   output logic [15:0] dm_addr,
   output logic [15:0] dm_wdata,
   output logic        dm_rd,
   output logic        dm_wr,
   input  logic [15:0] dm_rdata,
   input  logic        dm_done,
   output logic        stall_Out,
   output logic        PCsel_Out,
   output logic [15:0] BJAddr_Out,
   output logic        RegWrite_Out,
   output logic [2:0]  WR_Out,
   output logic [15:0] WD_Out,
   output logic        halt_Out,
   output logic        err
);
   localparam int unsigned DataW   = 16;
   localparam int unsigned RegIdxW = 3;

   typedef struct packed {
      logic [DataW-1:0]   aluResult;
      logic [RegIdxW-1:0] wr;
      logic               regWrite;
      logic [1:0]         wbSel;
      logic               memAccess;
      logic               branch;
      logic               jump;
      logic               halt;
      logic [2:0]         selFlag;
      logic               z;
      logic               n;
      logic               ofl;
      logic               cout;
      logic [DataW-1:0]   bjAddr;
      logic [DataW-1:0]   pcInc;
   } mStage_t;

   typedef enum logic {Idle, Busy} state_t;

   state_t           state;
   mStage_t          m;
   logic             mValid;
   logic             memIn;
   logic             complete;
   logic             loadM;
   logic             mMisaligned;
   logic             branchCond;
   logic             setFlag;
   logic [DataW-1:0] wbData;

   // Handshake status, branch resolution and writeback mux, all from the M register.
   always_comb begin
      memIn       = MemReadEn_In | MemWriteEn_In;
      stall_Out   = (state == Busy) & ~dm_done;
      complete    = mValid & ~stall_Out & ~halt_Out;
      // An instruction trailing a completing halt must not enter M.
      loadM       = ~stall_Out & ~halt_Out & ~(complete & m.halt);
      mMisaligned = m.memAccess & m.aluResult[0];

      branchCond = 1'b0;
      case (m.selFlag)
         3'b000:  branchCond = m.z;
         3'b001:  branchCond = ~m.z;
         3'b010:  branchCond = m.n;
         3'b011:  branchCond = ~m.n;
         default: branchCond = 1'b0;
      endcase

      setFlag = 1'b0;
      case (m.selFlag)
         3'b100:  setFlag = m.z;
         3'b101:  setFlag = m.n ^ m.ofl;
         3'b110:  setFlag = m.z | (m.n ^ m.ofl);
         3'b111:  setFlag = m.cout;
         default: setFlag = 1'b0;
      endcase

      wbData = m.aluResult;
      case (m.wbSel)
         2'b00:   wbData = m.aluResult;
         2'b01:   wbData = dm_rdata;
         2'b10:   wbData = m.pcInc;
         default: wbData = DataW'(setFlag);
      endcase

      PCsel_Out  = complete & (m.jump | (m.branch & branchCond));
      BJAddr_Out = m.bjAddr;
   end

   // M register, access FSM with registered strobes, writeback and sticky status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= Idle;
         mValid       <= 1'b0;
         m            <= '0;
         dm_rd        <= 1'b0;
         dm_wr        <= 1'b0;
         dm_addr      <= '0;
         dm_wdata     <= '0;
         RegWrite_Out <= 1'b0;
         WR_Out       <= '0;
         WD_Out       <= '0;
         halt_Out     <= 1'b0;
         err          <= 1'b0;
      end else begin
         if (state == Busy && dm_done) begin
            state <= Idle;
            dm_rd <= 1'b0;
            dm_wr <= 1'b0;
         end

         // A new access issued here overrides the retirement above (back-to-back).
         if (loadM) begin
            mValid <= ex_valid;
            m      <= '{aluResult: ALUResult_In, wr: WR_In, regWrite: RegWrite_In,
                        wbSel: RegWriteDataSel_In, memAccess: memIn, branch: Branch_In,
                        jump: Jump_In, halt: Halt_In, selFlag: SelFlag_In, z: Z_In,
                        n: N_In, ofl: Ofl_In, cout: Cout_In, bjAddr: BJAddr_In,
                        pcInc: PCInc_In};
            if (ex_valid && memIn) begin
               if (ALUResult_In[0]) begin
                  err <= 1'b1;
               end else begin
                  state    <= Busy;
                  dm_rd    <= MemReadEn_In;
                  dm_wr    <= MemWriteEn_In;
                  dm_addr  <= ALUResult_In;
                  dm_wdata <= RD2_In;
               end
            end
         end

         if (complete) begin
            RegWrite_Out <= m.regWrite & ~mMisaligned;
            WR_Out       <= m.wr;
            WD_Out       <= wbData;
            if (m.halt) halt_Out <= 1'b1;
         end else begin
            RegWrite_Out <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table, directed multi-cycle sequences and a
// randomized run against an in-order transaction-level model with a memory responder.
module tb_memory_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [15:0] ALUResult_In, RD2_In, BJAddr_In, PCInc_In;
   logic [2:0]  WR_In, SelFlag_In;
   logic        RegWrite_In, MemReadEn_In, MemWriteEn_In, Branch_In, Jump_In, Halt_In;
   logic [1:0]  RegWriteDataSel_In;
   logic        Z_In, N_In, Ofl_In, Cout_In;
   logic [15:0] dm_addr, dm_wdata, dm_rdata, BJAddr_Out, WD_Out;
   logic        dm_rd, dm_wr, dm_done, stall_Out, PCsel_Out, RegWrite_Out, halt_Out, err;
   logic [2:0]  WR_Out;

   memory_stage dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ALUResult_In(ALUResult_In),
      .RD2_In(RD2_In), .WR_In(WR_In), .RegWrite_In(RegWrite_In),
      .RegWriteDataSel_In(RegWriteDataSel_In), .MemReadEn_In(MemReadEn_In),
      .MemWriteEn_In(MemWriteEn_In), .Branch_In(Branch_In), .Jump_In(Jump_In),
      .Halt_In(Halt_In), .SelFlag_In(SelFlag_In), .Z_In(Z_In), .N_In(N_In),
      .Ofl_In(Ofl_In), .Cout_In(Cout_In), .BJAddr_In(BJAddr_In), .PCInc_In(PCInc_In),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rd(dm_rd), .dm_wr(dm_wr),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .stall_Out(stall_Out),
      .PCsel_Out(PCsel_Out), .BJAddr_Out(BJAddr_Out), .RegWrite_Out(RegWrite_Out),
      .WR_Out(WR_Out), .WD_Out(WD_Out), .halt_Out(halt_Out), .err(err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        valid;
      logic [15:0] alu, rd2, bj, pc;
      logic [2:0]  wr, sf;
      logic        rw, mr, mw, br, jp, ht;
      logic [1:0]  sel;
      logic        z, n, o, c;
   } exIn_t;

   typedef struct {
      logic [1:0]  sel;
      logic [2:0]  sf;
      logic [3:0]  flags;   // {Z, N, Ofl, Cout}
      logic        br, jp, rw;
      logic [2:0]  wr;
      logic [15:0] alu, pc, bj;
      logic        expRw;
      logic [15:0] expWd;
      logic        expPc;
   } vec_t;

   typedef struct {
      logic [2:0]  wr;
      logic [15:0] wd;
   } wb_t;

   vec_t        vecs [15];
   wb_t         wq [$];
   logic [15:0] rq [$];
   logic [15:0] realMem  [logic [15:0]];
   logic [15:0] modelMem [logic [15:0]];
   logic        errExp;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exIn_t bubble();
      exIn_t e;
      e = '{default: '0};
      return e;
   endfunction

   task automatic driveEx(input exIn_t e);
      ex_valid = e.valid;  ALUResult_In = e.alu;  RD2_In = e.rd2;  WR_In = e.wr;
      RegWrite_In = e.rw;  RegWriteDataSel_In = e.sel;  MemReadEn_In = e.mr;
      MemWriteEn_In = e.mw;  Branch_In = e.br;  Jump_In = e.jp;  Halt_In = e.ht;
      SelFlag_In = e.sf;  Z_In = e.z;  N_In = e.n;  Ofl_In = e.o;  Cout_In = e.c;
      BJAddr_In = e.bj;  PCInc_In = e.pc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b0;
      driveEx(bubble());
      dm_done  = 1'b0;
      dm_rdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Reference rules: condition codes and set-flag results.
   function automatic logic takenCond(input exIn_t e);
      case (e.sf)
         3'd0:    return e.z;
         3'd1:    return !e.z;
         3'd2:    return e.n;
         3'd3:    return !e.n;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] flagValue(input exIn_t e);
      logic lt;
      lt = e.n ^ e.o;
      case (e.sf)
         3'd4:    return e.z ? 16'd1 : 16'd0;
         3'd5:    return lt ? 16'd1 : 16'd0;
         3'd6:    return (e.z || lt) ? 16'd1 : 16'd0;
         3'd7:    return e.c ? 16'd1 : 16'd0;
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic [15:0] initVal(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] realRead(input logic [15:0] a);
      return realMem.exists(a) ? realMem[a] : initVal(a);
   endfunction

   // Architectural effect of one accepted instruction, in program order.
   task automatic modelAccept(input exIn_t e);
      logic        mis;
      logic [15:0] wd;
      wb_t         w;
      mis = (e.mr || e.mw) && e.alu[0];
      if (mis) errExp = 1'b1;
      case (e.sel)
         2'd0:    wd = e.alu;
         2'd1:    wd = modelMem.exists(e.alu) ? modelMem[e.alu] : initVal(e.alu);
         2'd2:    wd = e.pc;
         default: wd = flagValue(e);
      endcase
      if (e.mw && !mis) modelMem[e.alu] = e.rd2;
      if (e.rw && !mis) begin
         w.wr = e.wr;
         w.wd = wd;
         wq.push_back(w);
      end
      if (e.jp || (e.br && takenCond(e))) rq.push_back(e.bj);
   endtask

   function automatic exIn_t randInstr();
      exIn_t e;
      e = bubble();
      e.valid = ($urandom_range(0, 7) != 0);
      e.alu = 16'($urandom);  e.rd2 = 16'($urandom);  e.bj = 16'($urandom);
      e.pc = 16'($urandom);   e.wr = 3'($urandom);    e.sf = 3'($urandom);
      {e.z, e.n, e.o, e.c} = 4'($urandom);
      case ($urandom_range(0, 3))
         0: begin
            e.rw  = 1'($urandom);
            e.sel = 2'($urandom_range(0, 2));
            if (e.sel == 2'd1) e.sel = 2'd3;
            e.br  = ($urandom_range(0, 3) == 0);
            e.jp  = ($urandom_range(0, 7) == 0);
         end
         1: begin
            e.mr = 1'b1;  e.rw = 1'b1;  e.sel = 2'd1;
            e.alu = {11'h000, 4'($urandom), ($urandom_range(0, 15) == 0)};
         end
         2: begin
            e.mw = 1'b1;
            e.alu = {11'h000, 4'($urandom), ($urandom_range(0, 15) == 0)};
         end
         default: begin
            if ($urandom_range(0, 1) == 0) begin
               e.br = 1'b1;
            end else begin
               e.jp = 1'b1;  e.rw = 1'($urandom);  e.sel = 2'd2;
            end
         end
      endcase
      return e;
   endfunction

   exIn_t       e, cur;
   wb_t         w;
   int          stallCnt;
   logic        accepted, respActive;
   int          respWait;
   logic [15:0] respAddr;

   initial begin
      //          sel    sf      flags    br    jp    rw    wr    alu       pc        bj        expRw expWd     expPc
      vecs[0]  = '{2'd0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0002, 16'h0000, 1'b1, 16'h1234, 1'b0};
      vecs[1]  = '{2'd2, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd7, 16'h0000, 16'h0022, 16'h0000, 1'b1, 16'h0022, 1'b0};
      vecs[2]  = '{2'd3, 3'b100, 4'b1000, 1'b0, 1'b0, 1'b1, 3'd1, 16'h00F0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[3]  = '{2'd3, 3'b101, 4'b0100, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[4]  = '{2'd3, 3'b101, 4'b0110, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0};
      vecs[5]  = '{2'd3, 3'b110, 4'b0010, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[6]  = '{2'd3, 3'b111, 4'b0001, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[7]  = '{2'd3, 3'b111, 4'b1110, 1'b0, 1'b0, 1'b1, 3'd5, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0};
      vecs[8]  = '{2'd3, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b1, 3'd6, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0};
      vecs[9]  = '{2'd0, 3'b000, 4'b1000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0100, 1'b0, 16'h0000, 1'b1};
      vecs[10] = '{2'd0, 3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0100, 1'b0, 16'h0000, 1'b0};
      vecs[11] = '{2'd0, 3'b001, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0120, 1'b0, 16'h0000, 1'b1};
      vecs[12] = '{2'd0, 3'b010, 4'b0100, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0140, 1'b0, 16'h0000, 1'b1};
      vecs[13] = '{2'd0, 3'b011, 4'b0100, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0160, 1'b0, 16'h0000, 1'b0};
      vecs[14] = '{2'd2, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0000, 16'h0032, 16'h0200, 1'b1, 16'h0032, 1'b1};

      rst = 1'b0;
      driveEx(bubble());
      dm_done  = 1'b0;
      dm_rdata = 16'h0000;
      #3;
      chk1("reset dm_rd", dm_rd, 1'b0);            chk1("reset dm_wr", dm_wr, 1'b0);
      chk("reset dm_addr", dm_addr, 16'h0000);      chk("reset dm_wdata", dm_wdata, 16'h0000);
      chk1("reset stall", stall_Out, 1'b0);        chk1("reset PCsel", PCsel_Out, 1'b0);
      chk("reset BJAddr", BJAddr_Out, 16'h0000);    chk1("reset RegWrite", RegWrite_Out, 1'b0);
      chk("reset WR", 16'(WR_Out), 16'h0000);       chk("reset WD", WD_Out, 16'h0000);
      chk1("reset halt", halt_Out, 1'b0);          chk1("reset err", err, 1'b0);
      doReset();

      // Single-cycle instructions from the vector table, each followed by a bubble.
      for (int i = 0; i < 15; i++) begin
         e = bubble();
         e.valid = 1'b1;  e.sel = vecs[i].sel;  e.sf = vecs[i].sf;
         {e.z, e.n, e.o, e.c} = vecs[i].flags;
         e.br = vecs[i].br;  e.jp = vecs[i].jp;  e.rw = vecs[i].rw;  e.wr = vecs[i].wr;
         e.alu = vecs[i].alu;  e.pc = vecs[i].pc;  e.bj = vecs[i].bj;
         driveEx(e);
         tick();
         driveEx(bubble());
         #1;
         chk1($sformatf("vec%0d PCsel", i), PCsel_Out, vecs[i].expPc);
         chk1($sformatf("vec%0d stall", i), stall_Out, 1'b0);
         if (vecs[i].expPc) chk($sformatf("vec%0d BJAddr", i), BJAddr_Out, vecs[i].bj);
         tick();
         chk1($sformatf("vec%0d RegWrite", i), RegWrite_Out, vecs[i].expRw);
         if (vecs[i].expRw) begin
            chk($sformatf("vec%0d WR", i), 16'(WR_Out), 16'(vecs[i].wr));
            chk($sformatf("vec%0d WD", i), WD_Out, vecs[i].expWd);
         end
      end

      // Load from 0x0040 completing on the third strobe cycle; an ADD waits behind it.
      e = bubble();
      e.valid = 1'b1;  e.mr = 1'b1;  e.rw = 1'b1;  e.sel = 2'd1;  e.wr = 3'd4;  e.alu = 16'h0040;
      driveEx(e);
      tick();
      e = bubble();
      e.valid = 1'b1;  e.rw = 1'b1;  e.wr = 3'd5;  e.alu = 16'h5555;
      driveEx(e);
      stallCnt = 0;
      for (int k = 0; k < 3; k++) begin
         dm_done  = (k == 2);
         dm_rdata = (k == 2) ? 16'hBEEF : 16'h0BAD;
         #1;
         chk1($sformatf("load dm_rd cycle%0d", k), dm_rd, 1'b1);
         chk($sformatf("load dm_addr cycle%0d", k), dm_addr, 16'h0040);
         if (stall_Out) stallCnt++;
         tick();
         if (k < 2) chk1($sformatf("load early wb cycle%0d", k), RegWrite_Out, 1'b0);
      end
      dm_done = 1'b0;
      chk("load stall cycles", 16'(stallCnt), 16'd2);
      chk1("load RegWrite", RegWrite_Out, 1'b1);
      chk("load WR", 16'(WR_Out), 16'd4);
      chk("load WD", WD_Out, 16'hBEEF);
      chk1("load strobe dropped", dm_rd, 1'b0);
      driveEx(bubble());
      tick();
      chk1("held ADD RegWrite", RegWrite_Out, 1'b1);
      chk("held ADD WR", 16'(WR_Out), 16'd5);
      chk("held ADD WD", WD_Out, 16'h5555);
      tick();
      chk1("held ADD once", RegWrite_Out, 1'b0);

      // Zero-wait store to 0x0010.
      e = bubble();
      e.valid = 1'b1;  e.mw = 1'b1;  e.alu = 16'h0010;  e.rd2 = 16'hCAFE;
      driveEx(e);
      tick();
      driveEx(bubble());
      dm_done = 1'b1;
      #1;
      chk1("store dm_wr", dm_wr, 1'b1);
      chk1("store dm_rd", dm_rd, 1'b0);
      chk("store dm_wdata", dm_wdata, 16'hCAFE);
      chk("store dm_addr", dm_addr, 16'h0010);
      chk1("store stall", stall_Out, 1'b0);
      tick();
      dm_done = 1'b0;
      chk1("store dm_wr one cycle", dm_wr, 1'b0);
      chk1("store RegWrite", RegWrite_Out, 1'b0);

      // Misaligned load from 0x0003.
      e = bubble();
      e.valid = 1'b1;  e.mr = 1'b1;  e.rw = 1'b1;  e.sel = 2'd1;  e.wr = 3'd2;  e.alu = 16'h0003;
      driveEx(e);
      tick();
      driveEx(bubble());
      #1;
      chk1("misaligned no strobe", dm_rd, 1'b0);
      chk1("misaligned err", err, 1'b1);
      chk1("misaligned stall", stall_Out, 1'b0);
      tick();
      chk1("misaligned RegWrite", RegWrite_Out, 1'b0);
      repeat (2) tick();
      chk1("misaligned err sticky", err, 1'b1);

      // Reset mid-access, a late dm_done, then a clean instruction.
      e = bubble();
      e.valid = 1'b1;  e.mr = 1'b1;  e.rw = 1'b1;  e.sel = 2'd1;  e.wr = 3'd6;  e.alu = 16'h0080;
      driveEx(e);
      tick();
      driveEx(bubble());
      #1;
      chk1("busy dm_rd", dm_rd, 1'b1);
      chk1("busy stall", stall_Out, 1'b1);
      rst = 1'b0;
      #1;
      chk1("async reset dm_rd", dm_rd, 1'b0);
      chk1("async reset stall", stall_Out, 1'b0);
      chk1("async reset err", err, 1'b0);
      dm_done  = 1'b1;
      dm_rdata = 16'hDEAD;
      tick();
      rst = 1'b1;
      tick();
      chk1("late done stall", stall_Out, 1'b0);
      chk1("late done RegWrite", RegWrite_Out, 1'b0);
      chk1("late done dm_rd", dm_rd, 1'b0);
      dm_done = 1'b0;
      e = bubble();
      e.valid = 1'b1;  e.rw = 1'b1;  e.wr = 3'd2;  e.alu = 16'h0777;
      driveEx(e);
      tick();
      driveEx(bubble());
      tick();
      chk1("post-reset RegWrite", RegWrite_Out, 1'b1);
      chk("post-reset WR", 16'(WR_Out), 16'd2);
      chk("post-reset WD", WD_Out, 16'h0777);
      chk1("post-reset halt", halt_Out, 1'b0);

      // Halt followed by a load that must never issue.
      e = bubble();
      e.valid = 1'b1;  e.ht = 1'b1;  e.rw = 1'b1;  e.wr = 3'd1;  e.alu = 16'h1111;
      driveEx(e);
      tick();
      e = bubble();
      e.valid = 1'b1;  e.mr = 1'b1;  e.rw = 1'b1;  e.sel = 2'd1;  e.wr = 3'd3;  e.alu = 16'h0020;
      driveEx(e);
      tick();
      chk1("halt set", halt_Out, 1'b1);
      chk1("halt RegWrite", RegWrite_Out, 1'b1);
      chk("halt WD", WD_Out, 16'h1111);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk1($sformatf("halted no access %0d", k), dm_rd, 1'b0);
         chk1($sformatf("halted no wb %0d", k), RegWrite_Out, 1'b0);
         chk1($sformatf("halt sticky %0d", k), halt_Out, 1'b1);
      end

      // Randomized traffic with a random-latency memory responder.
      doReset();
      errExp     = 1'b0;
      respActive = 1'b0;
      respWait   = 0;
      respAddr   = 16'h0000;
      accepted   = 1'b1;
      cur        = bubble();
      for (int cyc = 0; cyc < 600; cyc++) begin
         tick();
         if (RegWrite_Out) begin
            if (wq.size() == 0) begin
               chk1("rand spurious writeback", RegWrite_Out, 1'b0);
            end else begin
               w = wq.pop_front();
               chk("rand WR", 16'(WR_Out), 16'(w.wr));
               chk("rand WD", WD_Out, w.wd);
            end
         end
         if (!respActive && (dm_rd || dm_wr)) begin
            respActive = 1'b1;
            respWait   = $urandom_range(0, 3);
            respAddr   = dm_addr;
         end else if (respActive) begin
            chk("rand dm_addr stable", dm_addr, respAddr);
            chk1("rand strobe held", dm_rd | dm_wr, 1'b1);
         end
         if (respActive) dm_done = (respWait == 0);
         else            dm_done = ($urandom_range(0, 3) == 0);
         if (respActive && respWait > 0) respWait--;
         dm_rdata = (respActive && dm_done && dm_rd) ? realRead(dm_addr) : 16'($urandom);
         if (accepted) begin
            cur = (cyc < 580) ? randInstr() : bubble();
            driveEx(cur);
         end
         #2;
         chk1("rand redirect during stall", stall_Out & PCsel_Out, 1'b0);
         if (PCsel_Out) begin
            if (rq.size() == 0) chk1("rand spurious redirect", PCsel_Out, 1'b0);
            else                chk("rand BJAddr", BJAddr_Out, rq.pop_front());
         end
         accepted = !stall_Out;
         if (accepted && cur.valid) modelAccept(cur);
         if (respActive && dm_done) begin
            if (dm_wr) realMem[dm_addr] = dm_wdata;
            respActive = 1'b0;
         end
      end
      chk("rand writebacks outstanding", 16'(wq.size()), 16'd0);
      chk("rand redirects outstanding", 16'(rq.size()), 16'd0);
      chk1("rand err", err, errExp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
